// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies the synchronized
// lock indication and releases the downstream reset only once lock is stable.
// Failed attempts are retried up to MAX_RETRIES before parking in FAIL.
//
// state      | meaning
// -----------+---------------------------------------------------------
// RESET_PLL  | PLL held in reset for RESET_CYCLES cycles
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// STABILIZE  | lock seen, must hold for STABLE_CYCLES consecutive cycles
// RUN        | lock stable, downstream logic released
// FAIL       | retries exhausted, PLL held in reset until relock or rst
module pll_lock_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fail,
   output logic       relock_ack,
   output logic [1:0] retry_cnt,
   output logic [7:0] loss_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       timer_q, timer_d;
   logic [1:0]             retry_q, retry_d;
   logic [7:0]             loss_q, loss_d;
   logic                   ack_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_q;
   logic                   locked_s;
   logic                   relock_acc;

   assign locked_s   = sync_q[SYNC_STAGES-1];
   assign relock_acc = relock_req & ~req_q;

   // lock synchronizer and relock request edge register
   always_ff @(posedge refclk) begin
      if (!rst) begin
         sync_q <= '0;
         req_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
         req_q  <= relock_req;
      end
   end

   // state register, counters and outputs decoded from the next state
   always_ff @(posedge refclk) begin
      if (!rst) begin
         state_q    <= ST_RESET_PLL;
         timer_q    <= '0;
         retry_q    <= '0;
         loss_q     <= '0;
         pll_rst    <= 1'b1;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         fail       <= 1'b0;
         relock_ack <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
         pll_rst    <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
         sys_rst_n  <= (state_d == ST_RUN);
         ready      <= (state_d == ST_RUN);
         fail       <= (state_d == ST_FAIL);
         relock_ack <= ack_d;
      end
   end

   // next-state, retry/loss bookkeeping; relock overrides everything but rst
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      ack_d   = 1'b0;
      if (relock_acc) begin
         state_d = ST_RESET_PLL;
         retry_d = '0;
         ack_d   = 1'b1;
      end else begin
         case (state_q)
            ST_RESET_PLL: begin
               if (timer_q == CNT_W'(RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = ST_STABILIZE;
               end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  if (retry_q == 2'(MAX_RETRIES)) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_RESET_PLL;
                     retry_d = retry_q + 2'd1;
                  end
               end
            end
            ST_STABILIZE: begin
               // a lock drop here is not a failed attempt, just start over
               if (!locked_s) state_d = ST_WAIT_LOCK;
               else if (timer_q == CNT_W'(STABLE_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_d = ST_RESET_PLL;
                  if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_RESET_PLL;
            end
         endcase
      end
      if (state_d == ST_RUN) retry_d = '0;
      // an accepted relock restarts the reset pulse even if already in RESET_PLL
      if (relock_acc || (state_d != state_q)) timer_d = '0;
      else if (timer_q != '1) timer_d = timer_q + CNT_W'(1);
   end

   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with short timing parameters: a vector table
// walks power-up, glitch, timeout, FAIL/relock and mid-sequence reset, then a
// loop drives 256 losses of lock to check loss_cnt saturation.
module tb_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, sys_rst_n, ready, fail, relock_ack;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   pll_lock_sequencer #(
      .RESET_CYCLES (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2),
      .SYNC_STAGES  (2),
      .CNT_W        (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .relock_req(relock_req),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .fail      (fail),
      .relock_ack(relock_ack),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt),
      .state     (state)
   );

   always #5 refclk = ~refclk;

   typedef struct packed {
      logic [2:0] st;
      logic       pll_rst;
      logic       sys_rst_n;
      logic       ready;
      logic       fail;
      logic       ack;
      logic [1:0] retry;
      logic [7:0] loss;
   } out_t;

   typedef struct {
      string name;
      bit    rst;
      bit    locked;
      bit    req;
      int    wait_n;
      int    st;
      int    retry;
      int    loss;
      bit    ack;
   } vec_t;

   vec_t tbl[$];
   out_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic out_t mk(int st, int retry, int loss, bit ack);
      out_t o;
      o.st        = 3'(st);
      o.pll_rst   = (st == 0) || (st == 4);
      o.sys_rst_n = (st == 3);
      o.ready     = (st == 3);
      o.fail      = (st == 4);
      o.ack       = ack;
      o.retry     = 2'(retry);
      o.loss      = 8'(loss);
      return o;
   endfunction

   function automatic out_t get_out();
      out_t o;
      o.st        = state;
      o.pll_rst   = pll_rst;
      o.sys_rst_n = sys_rst_n;
      o.ready     = ready;
      o.fail      = fail;
      o.ack       = relock_ack;
      o.retry     = retry_cnt;
      o.loss      = loss_cnt;
      return o;
   endfunction

   function automatic void add(string n, bit r, bit l, bit q, int w,
                               int st, int rt, int ls, bit ak);
      vec_t v;
      v.name = n; v.rst = r; v.locked = l; v.req = q; v.wait_n = w;
      v.st = st; v.retry = rt; v.loss = ls; v.ack = ak;
      tbl.push_back(v);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic check_next(input string name);
      out_t e, a;
      e = sb.pop_front();
      a = get_out();
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got st=%0d pll_rst=%0b sys_rst_n=%0b ready=%0b fail=%0b ack=%0b retry=%0d loss=%0d, expected st=%0d pll_rst=%0b sys_rst_n=%0b ready=%0b fail=%0b ack=%0b retry=%0d loss=%0d",
                  name, a.st, a.pll_rst, a.sys_rst_n, a.ready, a.fail, a.ack, a.retry, a.loss,
                  e.st, e.pll_rst, e.sys_rst_n, e.ready, e.fail, e.ack, e.retry, e.loss);
      end
   endtask

   task automatic wait_state(input logic [2:0] target, input int max_cyc,
                             input string name, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         if (state === target) begin
            ok = 1'b1;
            break;
         end
         @(negedge refclk);
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: state=%0d after %0d cycles, expected state=%0d", name, state, max_cyc, target);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int exp_loss;
      //   name            rst lck req wait st rt loss ack
      add("reset",          0,  0,  0,  3,  0, 0, 0, 0);
      add("release_3",      1,  0,  0,  3,  0, 0, 0, 0);
      add("release_4",      1,  0,  0,  1,  1, 0, 0, 0);
      add("wait_10",        1,  0,  0,  6,  1, 0, 0, 0);
      add("lock_10",        1,  1,  0, 10,  2, 0, 0, 0);
      add("lock_11",        1,  1,  0,  1,  3, 0, 0, 0);
      add("loss_2",         1,  0,  0,  2,  3, 0, 0, 0);
      add("loss_3",         1,  0,  0,  1,  0, 0, 1, 0);
      add("relock_wait",    1,  1,  0,  4,  1, 0, 1, 0);
      add("stab_0",         1,  1,  0,  1,  2, 0, 1, 0);
      add("stab_3",         1,  1,  0,  3,  2, 0, 1, 0);
      add("glitch_lo",      1,  0,  0,  1,  2, 0, 1, 0);
      add("glitch_hi",      1,  1,  0,  1,  2, 0, 1, 0);
      add("glitch_back",    1,  1,  0,  1,  1, 0, 1, 0);
      add("restab_0",       1,  1,  0,  1,  2, 0, 1, 0);
      add("restab_7",       1,  1,  0,  7,  2, 0, 1, 0);
      add("restab_run",     1,  1,  0,  1,  3, 0, 1, 0);
      add("nolock_rst",     1,  0,  0,  3,  0, 0, 2, 0);
      add("nolock_wait",    1,  0,  0,  4,  1, 0, 2, 0);
      add("nolock_w19",     1,  0,  0, 19,  1, 0, 2, 0);
      add("retry_1",        1,  0,  0,  1,  0, 1, 2, 0);
      add("retry_2",        1,  0,  0, 24,  0, 2, 2, 0);
      add("last_wait",      1,  0,  0, 23,  1, 2, 2, 0);
      add("fail_enter",     1,  0,  0,  1,  4, 2, 2, 0);
      add("fail_hold",      1,  0,  0, 30,  4, 2, 2, 0);
      add("relock_ack",     1,  0,  1,  1,  0, 0, 2, 1);
      add("relock_held",    1,  0,  1,  1,  0, 0, 2, 0);
      add("relock_held5",   1,  0,  1,  5,  1, 0, 2, 0);
      add("relock_low",     1,  0,  0,  1,  1, 0, 2, 0);
      add("mid_stab",       1,  1,  0,  3,  2, 0, 2, 0);
      add("mid_stab2",      1,  1,  0,  2,  2, 0, 2, 0);
      add("mid_rst",        0,  1,  0,  1,  0, 0, 0, 0);
      add("mid_release",    1,  0,  0,  4,  1, 0, 0, 0);
      add("stab_again",     1,  1,  0,  3,  2, 0, 0, 0);
      add("rst_with_req",   0,  1,  1,  1,  0, 0, 0, 0);
      add("rst_req_after",  1,  1,  0,  1,  0, 0, 0, 0);

      foreach (tbl[i]) begin
         rst        = tbl[i].rst;
         pll_locked = tbl[i].locked;
         relock_req = tbl[i].req;
         sb.push_back(mk(tbl[i].st, tbl[i].retry, tbl[i].loss, tbl[i].ack));
         cyc(tbl[i].wait_n);
         check_next(tbl[i].name);
      end

      exp_loss = 0;
      for (int i = 1; i <= 256; i++) begin
         pll_locked = 1'b1;
         wait_state(3'd3, 60, "sat_to_run", ok);
         if (!ok) break;
         pll_locked = 1'b0;
         wait_state(3'd0, 10, "sat_to_reset", ok);
         if (!ok) break;
         if (exp_loss < 255) exp_loss++;
         if (i == 1 || i == 255 || i == 256) begin
            sb.push_back(mk(0, 0, exp_loss, 1'b0));
            check_next("loss_sat");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
